// File: rtl/cswap_ladder.sv
`default_nettype none
// ============================================================================
//  Module   : cswap_ladder
//  Purpose  : Sequenced constant-time conditional swap for a Montgomery
//             ladder. Walks a loaded scalar MSB->LSB, swapping NPAIR operand
//             pairs under k[i]^k[i+1] per step, then a closing swap on k[0].
//  Revision : 1.0  initial release
// ============================================================================
module cswap_ladder #(
  parameter int WID   = 256,
  parameter int NPAIR = 2,
  parameter int NBITS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NBITS-1:0]      scalar,
  input  logic                  en,
  input  logic [NPAIR*WID-1:0]  a,
  input  logic [NPAIR*WID-1:0]  b,
  output logic [NPAIR*WID-1:0]  aswap,
  output logic [NPAIR*WID-1:0]  bswap,
  output logic                  vld,
  output logic                  swapbit,
  output logic                  kbit,
  output logic                  last,
  output logic                  ready,
  output logic                  err
);

  localparam int             IW      = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [IW-1:0]  IDX_TOP = IW'(NBITS - 1);
  localparam logic [IW-1:0]  IDX_ONE = IW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [NBITS-1:0] k;
  logic [NBITS-1:0] k_nxt;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_nxt;
  logic             prev;
  logic             prev_nxt;
  logic             kbit_nxt;
  logic             step;
  logic             s;

  logic [NPAIR*WID-1:0] aswap_nxt;
  logic [NPAIR*WID-1:0] bswap_nxt;

  // A step is accepted only outside IDLE; start always pre-empts en.
  assign step = en & ~start & (state != IDLE);

  // Swap decision: the state selects the source, never the data.
  assign s = (state == RUN) ? (k[idx] ^ prev) : prev;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start restarts from any state.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else if (en) begin
      case (state)
        RUN:     if (idx == '0) state_nxt = FINAL;
        FINAL:   state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // Next values of the scalar sequencing registers and the kbit decode.
  always_comb begin
    k_nxt    = k;
    idx_nxt  = idx;
    prev_nxt = prev;
    if (start) begin
      k_nxt    = scalar;
      idx_nxt  = IDX_TOP;
      prev_nxt = 1'b0;
    end else if (step && (state == RUN)) begin
      prev_nxt = k[idx];
      if (idx != '0) idx_nxt = idx - IDX_ONE;
    end
    kbit_nxt = (state_nxt == RUN) ? k_nxt[idx_nxt] : 1'b0;
  end

  // Sequencing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k    <= '0;
      idx  <= '0;
      prev <= 1'b0;
    end else begin
      k    <= k_nxt;
      idx  <= idx_nxt;
      prev <= prev_nxt;
    end
  end

  // Masked-XOR swap per pair; identical logic is exercised for s=0 and s=1.
  for (genvar p = 0; p < NPAIR; p++) begin : g_pair
    logic [WID-1:0] ap;
    logic [WID-1:0] bp;
    logic [WID-1:0] d;
    logic [WID-1:0] m;
    assign ap = a[p*WID +: WID];
    assign bp = b[p*WID +: WID];
    assign d  = ap ^ bp;
    assign m  = {WID{s}};
    assign aswap_nxt[p*WID +: WID] = ap ^ (m & d);
    assign bswap_nxt[p*WID +: WID] = bp ^ (m & d);
  end

  // Output registers: results hold until the next accepted step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aswap   <= '0;
      bswap   <= '0;
      vld     <= 1'b0;
      swapbit <= 1'b0;
      kbit    <= 1'b0;
      last    <= 1'b0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      vld   <= step;
      last  <= step & (state == FINAL);
      err   <= en & ~start & (state == IDLE);
      ready <= (state_nxt != IDLE);
      kbit  <= kbit_nxt;
      if (step) begin
        aswap   <= aswap_nxt;
        bswap   <= bswap_nxt;
        swapbit <= s;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cswap_ladder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cswap_ladder
//  Purpose  : Directed, table-driven self-checking bench for cswap_ladder
//             (single-pair and dual-pair instances, NBITS=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cswap_ladder;

  localparam int WID   = 256;
  localparam int NBITS = 4;

  typedef struct {
    logic             st;
    logic             en;
    logic [3:0]       sc;
    logic [WID-1:0]   a;
    logic [WID-1:0]   b;
    logic             vld;
    logic             sw;
    logic             last;
    logic             err;
    logic             ready;
    logic             kbit;
    logic [WID-1:0]   ea;
    logic [WID-1:0]   eb;
  } vec_t;

  logic clk;
  logic rst;
  logic start;
  logic en;
  logic [NBITS-1:0] scalar;

  logic [WID-1:0]   a1, b1, aswap1, bswap1;
  logic             vld1, swapbit1, kbit1, last1, ready1, err1;

  logic [2*WID-1:0] a2, b2, aswap2, bswap2;
  logic             vld2, swapbit2, kbit2, last2, ready2, err2;

  int n_checks;
  int n_fail;

  vec_t vecs[26];

  cswap_ladder #(.WID(WID), .NPAIR(1), .NBITS(NBITS)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .scalar(scalar), .en(en),
    .a(a1), .b(b1), .aswap(aswap1), .bswap(bswap1), .vld(vld1),
    .swapbit(swapbit1), .kbit(kbit1), .last(last1), .ready(ready1), .err(err1)
  );

  cswap_ladder #(.WID(WID), .NPAIR(2), .NBITS(NBITS)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .scalar(scalar), .en(en),
    .a(a2), .b(b2), .aswap(aswap2), .bswap(bswap2), .vld(vld2),
    .swapbit(swapbit2), .kbit(kbit2), .last(last2), .ready(ready2), .err(err2)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [2*WID-1:0] act, input logic [2*WID-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic e, input logic [3:0] sc,
                              input logic [WID-1:0] va, input logic [WID-1:0] vb,
                              input logic vl, input logic sw, input logic ls,
                              input logic er, input logic rd, input logic kb,
                              input logic [WID-1:0] ea, input logic [WID-1:0] eb);
    vec_t v;
    v.st = st; v.en = e; v.sc = sc; v.a = va; v.b = vb;
    v.vld = vl; v.sw = sw; v.last = ls; v.err = er; v.ready = rd; v.kbit = kb;
    v.ea = ea; v.eb = eb;
    return v;
  endfunction

  initial begin
    logic [WID-1:0] A, B, C, Z, BIG;
    A   = 256'd11;
    B   = 256'd11579;
    C   = 256'd12;
    Z   = '0;
    BIG = {{255{1'b1}}, 1'b0};
    n_checks = 0;
    n_fail   = 0;

    // en in IDLE after reset: err pulse only
    vecs[0]  = mk(0,1,4'b0000, A,B,   0,0,0,1,0,0, Z,Z);
    vecs[1]  = mk(0,0,4'b0000, Z,Z,   0,0,0,0,0,0, Z,Z);
    // scalar 1011: swapbits 1,1,1,0,1
    vecs[2]  = mk(1,0,4'b1011, Z,Z,   0,0,0,0,1,1, Z,Z);
    vecs[3]  = mk(0,1,4'b0000, A,B,   1,1,0,0,1,0, B,A);
    vecs[4]  = mk(0,1,4'b0000, A,B,   1,1,0,0,1,1, B,A);
    vecs[5]  = mk(0,1,4'b0000, A,B,   1,1,0,0,1,1, B,A);
    vecs[6]  = mk(0,1,4'b0000, A,B,   1,0,0,0,1,0, A,B);
    vecs[7]  = mk(0,1,4'b0000, A,B,   1,1,1,0,0,0, B,A);
    vecs[8]  = mk(0,0,4'b0000, Z,Z,   0,0,0,0,0,0, B,A);
    // scalar 0000: never swaps
    vecs[9]  = mk(1,0,4'b0000, Z,Z,   0,0,0,0,1,0, B,A);
    vecs[10] = mk(0,1,4'b0000, A,C,   1,0,0,0,1,0, A,C);
    vecs[11] = mk(0,1,4'b0000, A,C,   1,0,0,0,1,0, A,C);
    vecs[12] = mk(0,1,4'b0000, A,C,   1,0,0,0,1,0, A,C);
    vecs[13] = mk(0,1,4'b0000, A,C,   1,0,0,0,1,0, A,C);
    vecs[14] = mk(0,1,4'b0000, A,C,   1,0,1,0,0,0, A,C);
    // start and en together: start wins, en dropped silently
    vecs[15] = mk(1,1,4'b1000, A,C,   0,0,0,0,1,1, A,C);
    vecs[16] = mk(0,1,4'b0000, A,C,   1,1,0,0,1,0, C,A);
    // scalar 1111, abort after two steps, restart with 0001
    vecs[17] = mk(1,0,4'b1111, Z,Z,   0,0,0,0,1,1, C,A);
    vecs[18] = mk(0,1,4'b0000, BIG,Z, 1,1,0,0,1,1, Z,BIG);
    vecs[19] = mk(0,1,4'b0000, BIG,Z, 1,0,0,0,1,1, BIG,Z);
    vecs[20] = mk(1,0,4'b0001, Z,Z,   0,0,0,0,1,0, BIG,Z);
    vecs[21] = mk(0,1,4'b0000, BIG,Z, 1,0,0,0,1,0, BIG,Z);
    vecs[22] = mk(0,1,4'b0000, BIG,Z, 1,0,0,0,1,0, BIG,Z);
    vecs[23] = mk(0,1,4'b0000, BIG,Z, 1,0,0,0,1,1, BIG,Z);
    vecs[24] = mk(0,1,4'b0000, BIG,Z, 1,1,0,0,1,0, Z,BIG);
    vecs[25] = mk(0,1,4'b0000, BIG,Z, 1,1,1,0,0,0, Z,BIG);

    rst = 1'b1; start = 1'b0; en = 1'b0; scalar = '0;
    a1 = '0; b1 = '0;
    a2 = {256'd11, 256'd12};
    b2 = {256'd13, 256'd14};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst vld",   vld1,   1'b0);
    chk("rst ready", ready1, 1'b0);
    chk("rst err",   err1,   1'b0);
    chk("rst kbit",  kbit1,  1'b0);
    chk("rst last",  last1,  1'b0);
    chk("rst swapbit", swapbit1, 1'b0);
    chk("rst aswap", aswap1, '0);
    chk("rst bswap", bswap1, '0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors: drive on negedge, check 1 after posedge
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      start  = vecs[i].st;
      en     = vecs[i].en;
      scalar = vecs[i].sc;
      a1     = vecs[i].a;
      b1     = vecs[i].b;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d vld", i),   vld1,   vecs[i].vld);
      chk($sformatf("v%0d err", i),   err1,   vecs[i].err);
      chk($sformatf("v%0d ready", i), ready1, vecs[i].ready);
      chk($sformatf("v%0d kbit", i),  kbit1,  vecs[i].kbit);
      chk($sformatf("v%0d aswap", i), aswap1, vecs[i].ea);
      chk($sformatf("v%0d bswap", i), bswap1, vecs[i].eb);
      if (vecs[i].vld) begin
        chk($sformatf("v%0d swapbit", i), swapbit1, vecs[i].sw);
        chk($sformatf("v%0d last", i),    last1,    vecs[i].last);
      end
    end

    // en held high, two pairs, scalar 1010 -> swapbits 1,1,1,1,0
    @(negedge clk);
    start = 1'b1; en = 1'b0; scalar = 4'b1010;
    @(negedge clk);
    start = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic exp_s;
      exp_s = (i < 4);
      @(posedge clk);
      #1;
      chk($sformatf("held%0d vld", i),     vld2,     1'b1);
      chk($sformatf("held%0d swapbit", i), swapbit2, exp_s);
      chk($sformatf("held%0d last", i),    last2,    (i == 4));
      chk($sformatf("held%0d aswap", i),   aswap2,   exp_s ? {256'd13, 256'd14} : {256'd11, 256'd12});
      chk($sformatf("held%0d bswap", i),   bswap2,   exp_s ? {256'd11, 256'd12} : {256'd13, 256'd14});
    end
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("held end vld",   vld2,   1'b0);
    chk("held end ready", ready2, 1'b0);

    // Asynchronous reset mid-run discards the pending result
    @(negedge clk);
    start = 1'b1; scalar = 4'b1111;
    @(negedge clk);
    start = 1'b0; en = 1'b1; a1 = A; b1 = B;
    @(posedge clk);
    #1;
    chk("arst pre vld", vld1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst vld",    vld1,   1'b0);
    chk("arst ready",  ready1, 1'b0);
    chk("arst kbit",   kbit1,  1'b0);
    chk("arst aswap",  aswap1, '0);
    chk("arst aswap2", aswap2, '0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    @(posedge clk);
    #1;
    chk("arst post vld",   vld1,   1'b0);
    chk("arst post ready", ready1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cswap_ladder.md
# cswap_ladder

Sequenced constant-time conditional-swap unit for the Montgomery-ladder scalar multiplier. It loads a scalar, walks its bits MSB to LSB, and on each step request swaps NPAIR operand pairs under the swap bit k[i] XOR k[i+1]. After the last ladder step it performs the closing swap on k[0]. It sits between the ladder controller and the point register file and generalises the single-pair, externally driven cswap to multiple coordinates with internal bit sequencing.

## Interface
- WID, 256, operand width in bits.
- NPAIR, 2, number of (a,b) operand pairs swapped together (X and Z coordinates).
- NBITS, 256, scalar length; the bit index counter is $clog2(NBITS) bits.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; loads scalar and begins a ladder run.
- scalar  in  NBITS  scalar k, sampled when start=1.
- en  in  1  step request; a and b are sampled in the same cycle.
- a  in  NPAIR*WID  operand set A; pair p is a[p*WID +: WID].
- b  in  NPAIR*WID  operand set B, packed the same way.
- aswap  out  NPAIR*WID  registered swapped A.
- bswap  out  NPAIR*WID  registered swapped B.
- vld  out  1  one-cycle strobe; aswap, bswap, swapbit and last are valid.
- swapbit  out  1  swap decision s applied to this result.
- kbit  out  1  current scalar bit k[idx] in RUN, 0 otherwise; the ladder uses it for its data path.
- last  out  1  high with vld on the final-swap result.
- ready  out  1  high in RUN and FINAL.
- err  out  1  one-cycle pulse when en arrives in IDLE.

## Operation
- States:
  - IDLE, RUN, FINAL.
  - Reset puts the block in IDLE.
  - IDLE -> RUN on start.
  - RUN -> FINAL on en when idx==0.
  - FINAL -> IDLE on en.
  - Any state -> RUN on start; this is an abort and restart.
- Registers:
  - k (NBITS) holds the scalar.
  - idx runs from NBITS-1 down to 0.
  - prev holds the previous scalar bit.
  - On start: k<=scalar, idx<=NBITS-1, prev<=0.
- Step in RUN (en=1):
  - s = k[idx] ^ prev.
  - prev <= k[idx].
  - idx decrements. It does not wrap past 0; the last step moves the state to FINAL.
- Step in FINAL (en=1): s = prev. State returns to IDLE. last=1 with this vld.
- Swap, per pair p:
  - d = a_p ^ b_p; m = {WID{s}}.
  - aswap_p = a_p ^ (m & d); bswap_p = b_p ^ (m & d).
  - No data-dependent control path. Both s values drive the same logic, so timing and toggling do not depend on s.
- en in IDLE: ignored, no vld, err=1 for one cycle.
- start and en in the same cycle: start wins. en is dropped, with no vld and no err.
- start mid-run aborts the run. A result already registered from the previous cycle's en still strobes vld. No further results come from the aborted run.
- en held high advances one step per cycle, with back-to-back vld.

## Timing
- Latency is 1 cycle: en at edge t gives vld, aswap, bswap, swapbit and last at edge t+1.
- vld is high for exactly one cycle per accepted en.
- aswap and bswap hold their value until the next accepted en. They are not cleared when vld falls.
- kbit and ready are registered state decodes, valid in the cycle in which en is sampled.
- A full run takes NBITS+1 accepted en.
- Reset values: aswap=0, bswap=0, vld=0, swapbit=0, kbit=0, last=0, ready=0, err=0, k=0, idx=0, prev=0. State is IDLE.
- Asserting rst mid-run forces the reset values immediately; a pending result is lost.

## Test plan
Bench parameters: WID=256, NPAIR=1, NBITS=4.
- Reset, then start with scalar=4'b1011, then 5 en pulses with a=11, b=11579 -> swapbit sequence 1,1,1,0,1. Outputs (aswap,bswap) are (11579,11) for s=1 and (11,11579) for s=0. last=1 only on the 5th vld. ready drops after the 5th.
- scalar=4'b0000, 5 en with a=11, b=12 -> all swapbit=0, outputs (11,12) every time. last on the 5th.
- en with no start after reset -> err pulses once, vld stays 0, all outputs stay 0.
- start=1 and en=1 in the same cycle, scalar=4'b1000 -> no vld and no err. The next en gives swapbit=1.
- Run with scalar=4'b1111, a=2^256-2, b=0. After 2 steps assert start with scalar=4'b0001 -> the in-flight vld still appears, then the new run gives swapbit 0,0,0,1,1.
- en held high for 5 cycles with NPAIR=2, a={11,12}, b={13,14}, scalar=4'b1010 -> 5 consecutive vld cycles. Both pairs swap together with swapbit 1,1,1,1,0.
